wbu_trap_csr: RTL

//  Parametrised writeback/commit stage: retires one instruction per cycle from EXU, drives
//  the GPR write port, and owns the machine-mode CSR file with full trap entry/exit semantics
//  and 64-bit cycle/instret counters. One cycle after a control-changing commit it issues a

---
 rtl/wbu_trap_csr.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wbu_trap_csr.sv
// Writeback/commit stage: GPR write port, machine-mode CSR file with trap entry/exit,
// 64-bit cycle/instret counters and a registered flush/redirect to control steering.
module wbu_trap_csr #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned GPR_AW       = 4,
    parameter int unsigned NCAUSE_W     = 4,
    parameter logic [31:0] MSTATUS_RST  = 32'h0000_1800,
    parameter logic [31:0] MTVEC_RST    = 32'h0000_0000,
    parameter logic [31:0] MVENDORID    = 32'h7973_7978,
    parameter logic [31:0] MARCHID      = 32'h015f_deeb,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [GPR_AW-1:0]   in_gpr_waddr,
    input  logic [XLEN-1:0]     in_gpr_wdata,
    input  logic                in_csr_wen,
    input  logic [11:0]         in_csr_waddr,
    input  logic [XLEN-1:0]     in_csr_wdata,
    input  logic                in_exc,
    input  logic [NCAUSE_W-1:0] in_cause,
    input  logic                in_ret,
    input  logic                in_fencei,
    output logic                gpr_wen,
    output logic [GPR_AW-1:0]   gpr_waddr,
    output logic [XLEN-1:0]     gpr_wdata,
    input  logic [11:0]         csr_raddr,
    output logic [XLEN-1:0]     csr_rdata,
    output logic                cs_flush,
    output logic [XLEN-1:0]     cs_dnpc,
    output logic                fencei
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;

    logic [XLEN-1:0] mstatus, mtvec, mscratch, mepc, mcause;
    logic [XLEN-1:0] mstatus_n, mtvec_n, mscratch_n, mepc_n, mcause_n;
    logic [63:0]     mcycle, minstret, mcycle_n, minstret_n, mcycle_inc, minstret_inc;
    logic [XLEN-1:0] pc_q, target_q, target_n;
    logic            flush_q, fencei_q;
    logic            commit, trap, mret, csr_we;

    assign in_ready  = 1'b1;
    assign commit    = in_valid;
    // exc together with ret (ebreak halt) is handled as an ordinary trap entry
    assign trap      = commit & in_exc;
    assign mret      = commit & in_ret & ~in_exc;
    assign csr_we    = commit & in_csr_wen;

    assign gpr_wen   = commit & ~in_exc & (in_gpr_waddr != '0);
    assign gpr_waddr = in_gpr_waddr;
    assign gpr_wdata = in_gpr_wdata;

    assign mcycle_inc   = mcycle + 64'd1;
    assign minstret_inc = commit ? minstret + 64'd1 : minstret;

    always_comb begin
        mstatus_n  = mstatus;
        mtvec_n    = mtvec;
        mscratch_n = mscratch;
        mepc_n     = mepc;
        mcause_n   = mcause;
        mcycle_n   = mcycle_inc;
        minstret_n = minstret_inc;
        if (csr_we) begin
            case (in_csr_waddr)
                A_MSTATUS:   mstatus_n  = in_csr_wdata;
                A_MTVEC:     mtvec_n    = {in_csr_wdata[XLEN-1:2], 2'b00};
                A_MSCRATCH:  mscratch_n = in_csr_wdata;
                A_MEPC:      mepc_n     = {in_csr_wdata[XLEN-1:2], 2'b00};
                A_MCAUSE:    mcause_n   = in_csr_wdata;
                // the written half is replaced; the other half does not see a carry this cycle
                A_MCYCLE:    mcycle_n   = {mcycle[63:32], in_csr_wdata};
                A_MCYCLEH:   mcycle_n   = {in_csr_wdata, mcycle_inc[31:0]};
                A_MINSTRET:  minstret_n = {minstret[63:32], in_csr_wdata};
                A_MINSTRETH: minstret_n = {in_csr_wdata, minstret_inc[31:0]};
                default: ;
            endcase
        end
        if (trap) begin
            mepc_n        = in_pc;
            mcause_n      = XLEN'(in_cause);
            mstatus_n     = mstatus;
            mstatus_n[7]  = mstatus[3];
            mstatus_n[3]  = 1'b0;
            mstatus_n[12:11] = 2'b11;
        end else if (mret) begin
            mstatus_n     = mstatus;
            mstatus_n[3]  = mstatus[7];
            mstatus_n[7]  = 1'b1;
            mstatus_n[12:11] = 2'b11;
        end
        target_n = in_pc + XLEN'(4);
        if (trap)
            target_n = mtvec_n;
        else if (mret)
            target_n = mepc_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus  <= MSTATUS_RST;
            mtvec    <= MTVEC_RST;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
            pc_q     <= '0;
            target_q <= '0;
            flush_q  <= 1'b0;
            fencei_q <= 1'b0;
        end else begin
            mstatus  <= mstatus_n;
            mtvec    <= mtvec_n;
            mscratch <= mscratch_n;
            mepc     <= mepc_n;
            mcause   <= mcause_n;
            mcycle   <= HAS_COUNTERS ? mcycle_n   : '0;
            minstret <= HAS_COUNTERS ? minstret_n : '0;
            if (commit)
                pc_q <= in_pc;
            target_q <= target_n;
            flush_q  <= commit & (in_csr_wen | in_exc | in_ret | in_fencei);
            fencei_q <= commit & in_fencei;
        end
    end

    // outside a flush cycle the redirect target falls back to the sequential next pc
    assign cs_flush = flush_q;
    assign cs_dnpc  = flush_q ? target_q : pc_q + XLEN'(4);
    assign fencei   = fencei_q;

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            A_MSTATUS:   csr_rdata = mstatus;
            A_MTVEC:     csr_rdata = mtvec;
            A_MSCRATCH:  csr_rdata = mscratch;
            A_MEPC:      csr_rdata = mepc;
            A_MCAUSE:    csr_rdata = mcause;
            A_MCYCLE:    csr_rdata = mcycle[31:0];
            A_MCYCLEH:   csr_rdata = mcycle[63:32];
            A_MINSTRET:  csr_rdata = minstret[31:0];
            A_MINSTRETH: csr_rdata = minstret[63:32];
            A_MVENDORID: csr_rdata = MVENDORID;
            A_MARCHID:   csr_rdata = MARCHID;
            default:     csr_rdata = '0;
        endcase
    end

endmodule
